// File: rtl/uart_rx_fifo.sv
// UART receive front end: 16x oversampled 8N1 deframer feeding a small FWFT FIFO.
// Define UART_RX_PARITY_EN to build the 8E1 variant with parity checking.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 163,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       sys_rstn,
  input  logic       uart_rxd,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [2:0] rx_count,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge
  // START     | confirming the start bit at mid-bit
  // DATA      | shifting in 8 data bits, LSB first
  // PARITY    | sampling the even-parity bit (8E1 build only)
  // STOP      | sampling the stop bit, push or flag
  // WAIT_HIGH | framing error seen, waiting for the line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam int          AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] TC = 16'(BAUD_DIV - 1);

  state_t      state;
  logic        sync1, rxs;
  logic [15:0] baud_cnt;
  logic [3:0]  sc;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        tick, mid_start, mid_bit;
  logic        stop_ok, push, frame_set, parity_set;

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      rxs   <= sync1;
    end
  end

  assign tick      = (state != IDLE) && (baud_cnt == TC);
  assign mid_start = tick && (sc == 4'd7);
  assign mid_bit   = tick && (sc == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      sc       <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      if (state == IDLE || tick) baud_cnt <= '0;
      else                       baud_cnt <= baud_cnt + 16'd1;
      if (tick) sc <= sc + 4'd1;

      case (state)
        IDLE: begin
          sc      <= '0;
          bit_cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (mid_start) begin
            sc    <= '0;
            state <= rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (mid_bit) begin
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= PARITY;
`else
            if (bit_cnt == 3'd7) state <= STOP;
`endif
          end
        end
        PARITY: begin
          if (mid_bit) begin
`ifdef UART_RX_PARITY_EN
            par_bad <= rxs ^ (^shift);
`endif
            state <= STOP;
          end
        end
        STOP: begin
          if (mid_bit) state <= rxs ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_ok   = (state == STOP) && mid_bit && rxs;
  assign frame_set = (state == STOP) && mid_bit && !rxs;
`ifdef UART_RX_PARITY_EN
  assign push       = stop_ok && !par_bad;
  assign parity_set = stop_ok && par_bad;
`else
  assign push       = stop_ok;
  assign parity_set = 1'b0;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [2:0]    count;
  logic          pop, full, accept, ovr_set;

  assign pop     = rd_en && (count != 3'd0);
  assign full    = (count == 3'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign accept  = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  logic frame_q, ovr_q, par_q;

  always_ff @(posedge clk_in) begin
    if (!sys_rstn) begin
      frame_q <= 1'b0;
      ovr_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      frame_q <= frame_set  | (frame_q & ~clr_err);
      ovr_q   <= ovr_set    | (ovr_q   & ~clr_err);
      par_q   <= parity_set | (par_q   & ~clr_err);
    end
  end

  assign rx_data    = mem[rd_ptr];
  assign rx_valid   = (count != 3'd0);
  assign rx_count   = count;
  assign frame_err  = frame_q;
  assign overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, expected bytes queued, popped on read.
module tb_uart_rx_fifo;
  localparam int BAUD_DIV = 4;
  localparam int BIT      = 16 * BAUD_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Negedges from the start-bit drive to the cycle whose closing edge samples the stop bit.
  localparam int STOP_TICK = 35 + BIT * (NBITS - 1) - 1;

  logic       clk_in = 1'b0;
  logic       sys_rstn, uart_rxd, rd_en, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err, overrun, parity_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .sys_rstn(sys_rstn), .uart_rxd(uart_rxd), .rd_en(rd_en),
    .clr_err(clr_err), .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk_in);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = ^b;
    repeat (BIT) @(negedge clk_in);
`endif
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk_in);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_par(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk_in);
    end
    uart_rxd = ~(^b);
    repeat (BIT) @(negedge clk_in);
    uart_rxd = 1'b1;
    repeat (BIT) @(negedge clk_in);
  endtask
`endif

  task automatic read_byte(input string tag);
    logic [31:0] exp;
    exp = (sb.size() != 0) ? {24'h0, sb.pop_front()} : 32'hDEAD;
    chk({tag, "_valid"}, rx_valid, 1);
    chk({tag, "_data"}, rx_data, exp);
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk_in);
    clr_err = 1'b0;
  endtask

  initial begin
    sys_rstn = 1'b0;
    uart_rxd = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(negedge clk_in);
    sys_rstn = 1'b1;
    @(negedge clk_in);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", parity_err, 0);
    repeat (10) @(negedge clk_in);

    // single byte with exact delivery cycle
    sb.push_back(8'hA5);
    fork
      send_byte(8'hA5);
      begin
        repeat (STOP_TICK) @(negedge clk_in);
        chk("single_pre_valid", rx_valid, 0);
        @(negedge clk_in);
        chk("single_valid", rx_valid, 1);
        chk("single_count", rx_count, 1);
        chk("single_data", rx_data, 8'hA5);
      end
    join
    read_byte("single_rd");
    chk("single_empty", rx_valid, 0);
    chk("single_cnt0", rx_count, 0);

    // overrun: five bytes, no reads
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(8'(i));
      send_byte(8'(i));
    end
    chk("ovr_count", rx_count, 4);
    chk("ovr_flag", overrun, 1);
    for (int i = 0; i < 4; i++) read_byte("ovr_rd");
    chk("ovr_empty", rx_count, 0);
    pulse_clr();
    chk("ovr_clr", overrun, 0);

    // line held low from reset release
    uart_rxd = 1'b0;
    sys_rstn = 1'b0;
    repeat (3) @(negedge clk_in);
    sys_rstn = 1'b1;
    repeat (2000) @(negedge clk_in);
    chk("low_ferr", frame_err, 1);
    chk("low_count", rx_count, 0);
    pulse_clr();
    repeat (800) @(negedge clk_in);
    chk("low_no_refire", frame_err, 0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk_in);
    sb.push_back(8'h3C);
    send_byte(8'h3C);
    read_byte("low_rd");

    // glitch rejection
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk_in);
    uart_rxd = 1'b1;
    repeat (100) @(negedge clk_in);
    chk("glitch_count", rx_count, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_ovr", overrun, 0);

    // fill, then pop on the stop-tick cycle of a fifth byte
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(16 * i));
      send_byte(8'(16 * i));
    end
    chk("fill_count", rx_count, 4);
    sb.push_back(8'h77);
    fork
      send_byte(8'h77);
      begin
        repeat (STOP_TICK) @(negedge clk_in);
        read_byte("pp_rd");
      end
    join
    chk("pp_count", rx_count, 4);
    chk("pp_ovr", overrun, 0);
    for (int i = 0; i < 4; i++) read_byte("pp_drain");
    chk("pp_empty", rx_valid, 0);

    // reset during data bit 3
    sb.push_back(8'h11);
    send_byte(8'h11);
    uart_rxd = 1'b0;
    repeat (BIT * 4 + BIT / 2) @(negedge clk_in);
    sys_rstn = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk_in);
    sys_rstn = 1'b1;
    sb.delete();
    @(negedge clk_in);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_count", rx_count, 0);
    chk("mid_rst_ferr", frame_err, 0);
    repeat (BIT * 12) @(negedge clk_in);
    chk("mid_rst_no_partial", rx_count, 0);
    sb.push_back(8'h5A);
    send_byte(8'h5A);
    chk("mid_rst_cnt1", rx_count, 1);
    read_byte("mid_rst_rd");

`ifdef UART_RX_PARITY_EN
    send_bad_par(8'h03);
    chk("par_err", parity_err, 1);
    chk("par_nopush", rx_count, 0);
    pulse_clr();
    chk("par_clr", parity_err, 0);
    sb.push_back(8'h03);
    send_byte(8'h03);
    read_byte("par_rd");
    chk("par_ok", parity_err, 0);
`else
    chk("par_tied", parity_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the MIPS system's UART peripheral.
- Samples the board `uart_rxd` pin with 16x oversampling and deframes 8N1 characters (8E1 when parity is compiled in).
- Stores received bytes in a 4-entry first-word-fall-through FIFO.
- The CPU-side UART register file drains the FIFO. It reads the head byte, the occupancy and sticky error flags.

## Interface
Parameters:
- `BAUD_DIV`, default 163: `clk_in` cycles per oversample tick (25 MHz / (9600 × 16)). Legal range is 2..65535.
- `FIFO_DEPTH`, default 4: number of FIFO entries. Fixed power of two.

Ports:
- `clk_in`  in  1: system clock. All logic is on the rising edge.
- `sys_rstn`  in  1: reset. One clock; reset is synchronous and active-low.
- `uart_rxd`  in  1: asynchronous serial line, idle high.
- `rd_en`  in  1: pops the head entry when `rx_valid`=1. Ignored when the FIFO is empty.
- `clr_err`  in  1: clears all sticky error flags.
- `rx_data`  out  8: FIFO head byte. Valid while `rx_valid`=1.
- `rx_valid`  out  1: FIFO not empty.
- `rx_count`  out  3: FIFO occupancy, 0..4.
- `frame_err`  out  1: sticky. A stop bit was sampled low.
- `overrun`  out  1: sticky. A good byte arrived while the FIFO was full.
- `parity_err`  out  1: sticky. Parity mismatch.

## Operation
Input synchronizer:
- `uart_rxd` passes through a 2-flop synchronizer. Its output is `rxs`.
- Both flops reset to 1.

Tick generator:
- 16-bit counter counts 0..BAUD_DIV-1 and pulses `tick` when it reaches BAUD_DIV-1.
- It is held at 0 in IDLE and restarts from 0 on start detection.

Sample counter:
- 4-bit counter `sc` advances on each `tick`.

FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE**: `rxs`=0 → START, with `sc`=0.
- **START**: on the 8th tick (mid start bit), `rxs`=0 → DATA with `sc` cleared. `rxs`=1 → IDLE (glitch rejected, nothing flagged).
- **DATA**: samples on every 16th tick (mid bit), LSB first, into a shift register. After bit 7 → PARITY if compiled in, else → STOP.
- **PARITY**: samples mid bit and compares against even parity of the 8 data bits.
- **STOP**, on the mid-bit sample:
  - `rxs`=1 and no parity error → push the byte and go to IDLE (the next start bit can be seen half a bit early).
  - `rxs`=1 with a parity error → set `parity_err`, discard the byte, go to IDLE.
  - `rxs`=0 → set `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH**: stays until `rxs`=1, then → IDLE. A line held low (break, or an unconnected pin driven 0) therefore yields exactly one `frame_err` and no further frames.

FIFO:
- Circular buffer with 2-bit read and write pointers plus a 3-bit count.
- `rx_data` = mem[rd_ptr], combinational from the registers.
- Push while full: the byte is dropped and `overrun` is set. Exception: a simultaneous `rd_en` with `rx_valid`=1 frees a slot, so the push is accepted and `overrun` is not set.
- Push and pop in the same cycle when not full or empty: `rx_count` is unchanged.
- Pointers wrap modulo 4.

Error flags:
- Set on the event cycle; cleared by `clr_err`.
- If a set and `clr_err` coincide, the set wins.

## Timing
- Reset values: `rx_data`=0x00 (storage is cleared), `rx_valid`=0, `rx_count`=0, all error flags 0, FSM in IDLE.
- Reset mid-frame abandons the frame. No partial byte is ever pushed.
- Edge detection latency: 2 cycles from `uart_rxd` to `rxs`, then 1 cycle from `rxs` to START.
- Bit period is 16 × BAUD_DIV cycles.
- Byte delivery: `rx_valid` and `rx_count` update on the clock edge after the stop-bit `tick`.
- Pop: on the cycle after `rd_en`, `rx_data` shows the next entry and `rx_count` decrements.
- A pop and `clr_err` may occur on any cycle, independent of the FSM.

## Configuration
Macro `UART_RX_PARITY_EN`:
- **Defined**: frame is 8E1. The PARITY state is present, a mismatch sets `parity_err` and the byte is discarded.
- **Undefined**: frame is 8N1. DATA goes directly to STOP and `parity_err` is tied to 0. The port exists in both builds so the register file interface is stable.

## Test plan
All scenarios use `BAUD_DIV`=4, so one bit is 64 cycles.
- **Single byte**: send 0xA5 as 8N1 → one cycle after the stop tick, `rx_valid`=1, `rx_data`=0xA5, `rx_count`=1. Then `rd_en` for 1 cycle → `rx_valid`=0, `rx_count`=0.
- **Overrun**: send 0x01..0x05 back-to-back with no reads → `rx_count`=4, `overrun`=1, and successive reads return 0x01, 0x02, 0x03, 0x04. Then `clr_err` → `overrun`=0.
- **Line held low**: keep `uart_rxd`=0 from reset release for 2000 cycles → `frame_err`=1, `rx_count`=0, FSM in WAIT_HIGH. Raise the line and send 0x3C → 0x3C received.
- **Glitch and push/pop**: a 20-cycle low pulse → no byte and no flags. Fill the FIFO to 4, then assert `rd_en` exactly on the stop-tick cycle of a 5th byte 0x77 → `overrun`=0, `rx_count`=4, and 0x77 is last out.
- **Reset mid-frame**: assert `sys_rstn`=0 during data bit 3 → all outputs return to reset values, and the next full frame 0x5A is received correctly.
- **Parity (`UART_RX_PARITY_EN` defined)**: send 0x03 with parity bit 1 → `parity_err`=1 and no push. Send 0x03 with parity bit 0 → byte is pushed.
